aes_output_buffer: RTL
======================

// Module: aes_output_buffer
// PURPOSE
// - Downstream stage of the AES decryption pipeline; captures each finished 128-bit plaintext block.
// - A block is finished when the pipeline raises data_done.
// - Stores blocks in a DEPTH-entry FIFO and drains them to the host side as 32-bit words.
// - Drives is_full back to the decryption pipeline, which freezes all of its stage registers while it is high.
// PARAMETERS
// - DEPTH   4                 number of 128-bit block entries; power of two, >= 2
// - PTR_W   $clog2(DEPTH)     block pointer width (derived; do not override)
// PORTS
// - clk           in   1    system clock, rising edge
// - n_rst         in   1    asynchronous active-low reset
// - data_done     in   1    decryption pipeline reports a finished block on data_output this cycle
// - data_output   in   128  finished plaintext block from the decryption pipeline
// - is_full       out  1    buffer full; decryption pipeline must hold its registers
// - flush         in   1    synchronous clear of all stored blocks and the word pointer
// - rd_req        in   1    host pops one 32-bit word
// - rd_data       out  32   current head word
// - rd_empty      out  1    no word available
// - block_count   out  PTR_W+1  number of stored blocks, 0..DEPTH
// BEHAVIOUR
// - Reset values (n_rst=0, asynchronous):
//   - all pointers and block_count = 0; word index = 0
//   - is_full=0, rd_empty=1, rd_data=0
//   - memory contents need not be reset
// - Push:
//   - Occurs when data_done && !is_full.
//   - The block is written at wr_ptr, wr_ptr increments with wrap at DEPTH, and block_count increments.
//   - The pipeline holds data_done high and data_output stable while stalled, so a block presented while
//     is_full=1 is not lost: it is pushed in the first cycle is_full is 0.
//   - There is no edge detection on data_done; each done cycle with !is_full is a distinct block.
// - is_full = (block_count == DEPTH). It is decoded from registers only, with no combinational path from
//   rd_req or data_done.
// - Read side:
//   - rd_empty = (block_count == 0).
//   - rd_data = word[widx] of the entry at rd_ptr; rd_data = 0 when empty.
//   - Word order: widx 0 -> bits [127:96], 1 -> [95:64], 2 -> [63:32], 3 -> [31:0], i.e. most
//     significant word first.
//   - rd_req && !rd_empty advances widx.
//   - When widx == 3 the pop retires the block: widx returns to 0, rd_ptr increments with wrap, and
//     block_count decrements.
//   - rd_req while empty is ignored, with no state change.
// - Latency: a block pushed at edge N gives rd_empty=0 and a valid rd_data after edge N (first cycle N+1).
// - Simultaneous push and block-retire in one cycle:
//   - block_count is unchanged; both pointers advance.
//   - is_full is evaluated from the pre-edge count. When the buffer is full, a retire frees space one
//     cycle before the stalled block is accepted (one bubble, intentional).
// - flush:
//   - Clears pointers, widx and block_count at the next edge and takes priority over push and pop.
//   - A push coincident with flush is dropped.
// - Reset mid-drain: the partial block and all remaining blocks are discarded.
// - block_count arithmetic uses PTR_W+1 bits; it must never exceed DEPTH or underflow. Both are
//   checked with assertions.
// STRUCTURE
// - aes_pkg holds:
//   - AES_BLOCK_W = 128, AES_WORD_W = 32, AES_WORDS = 4
//   - AES_DONE_STATE = 5'b11010, the final round-state code
//   - typedef aes_block_t = logic [127:0]
// - One sub-module, aes_buf_mem:
//   - DEPTH x 128 register array
//   - one synchronous write port, one combinational read port
// - Top level holds the pointers, widx, count and word mux.
// TESTING
// - Reset: after n_rst pulse -> rd_empty=1, is_full=0, block_count=0, rd_data=0.
// - Single block:
//   - Stimulus: data_done=1 for one cycle with data_output=128'h00112233_44556677_8899AABB_CCDDEEFF,
//     then 4 rd_req.
//   - Required: 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF in order, then rd_empty=1.
// - Fill and stall:
//   - Stimulus: DEPTH+1 consecutive done blocks with values 1..5, data_done held high while stalled,
//     as the pipeline does.
//   - Required: is_full=1 after the 4th push. Block 5 is not written until one full block is drained;
//     all 5 blocks are then read in order 1..5.
// - Wrap:
//   - Stimulus: 10 blocks with interleaved pushes and drains.
//   - Required: pointers wrap and the read sequence matches the push sequence exactly.
// - Simultaneous events: push in the same cycle as the 4th-word pop of the previous block ->
//   block_count unchanged and both blocks intact.
// - Flush and empty read:
//   - Stimulus: flush with 2 blocks stored, mid-word.
//   - Required: block_count=0, rd_empty=1, and next-block reads start at word 0.
//   - rd_req while empty leaves all state unchanged.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath constants and types for the decryption pipeline and its output buffer.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned AES_WORD_W  = 32;
    localparam int unsigned AES_WORDS   = 4;
    localparam int unsigned AES_WIDX_W  = $clog2(AES_WORDS);

    localparam logic [4:0] AES_DONE_STATE = 5'b11010;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

endpackage

// File: rtl/aes_output_buffer_if.sv
// Pipeline-facing and host-facing signals of the AES output buffer.
interface aes_output_buffer_if
    import aes_pkg::*;
#(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic                  data_done;
    aes_block_t            data_output;
    logic                  is_full;
    logic                  flush;
    logic                  rd_req;
    logic [AES_WORD_W-1:0] rd_data;
    logic                  rd_empty;
    logic [PTR_W:0]        block_count;

    modport master (
        output data_done, data_output, flush, rd_req,
        input  is_full, rd_data, rd_empty, block_count
    );

    modport slave (
        input  data_done, data_output, flush, rd_req,
        output is_full, rd_data, rd_empty, block_count
    );

endinterface

// File: rtl/aes_buf_mem.sv
// Block storage: DEPTH x 128-bit registers, synchronous write, combinational read.
module aes_buf_mem
    import aes_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  aes_block_t       wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output aes_block_t       rdata_o
);

    aes_block_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/aes_output_buffer.sv
// Captures finished AES plaintext blocks into a FIFO and drains them to the host
// as 32-bit words, most significant word first.
module aes_output_buffer
    import aes_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input logic                clk,
    input logic                n_rst,
    aes_output_buffer_if.slave bus
);

    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [AES_WIDX_W-1:0] LAST_WORD = AES_WIDX_W'(AES_WORDS - 1);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AES_WIDX_W-1:0] widx_q, widx_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  full, empty, push, pop, retire;
    aes_block_t            head;
    logic [AES_WORD_W-1:0] rd_word;

    // Full/empty come from the count register only, so is_full has no path from inputs.
    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign push   = bus.data_done && !full;
    assign pop    = bus.rd_req && !empty;
    assign retire = pop && (widx_q == LAST_WORD);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        widx_d   = widx_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            widx_d   = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                widx_d = widx_q + 1'b1;
                if (retire) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end
            case ({push, retire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            widx_q   <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            widx_q   <= widx_d;
            count_q  <= count_d;
        end
    end

    aes_buf_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (push && !bus.flush),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.data_output),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    always_comb begin
        rd_word = '0;
        if (!empty) begin
            unique case (widx_q)
                2'd0:    rd_word = head[3*AES_WORD_W +: AES_WORD_W];
                2'd1:    rd_word = head[2*AES_WORD_W +: AES_WORD_W];
                2'd2:    rd_word = head[1*AES_WORD_W +: AES_WORD_W];
                default: rd_word = head[0 +: AES_WORD_W];
            endcase
        end
    end

    assign bus.is_full     = full;
    assign bus.rd_empty    = empty;
    assign bus.rd_data     = rd_word;
    assign bus.block_count = count_q;

    a_count_max: assert property (@(posedge clk) disable iff (!n_rst) count_q <= FULL_CNT);
    a_count_min: assert property (@(posedge clk) disable iff (!n_rst)
                                  (empty && !push) |-> !retire);

endmodule
